// File: rtl/apb_wait_state_slave_if.sv
// APB bus bundle between the bridge (master) and the wait-state completer (slave).
// Signals: PADDR/PWDATA/PWRITE/PSEL/PENABLE requester side; PRDATA/PREADY/PSLVERROR response.
interface apb_wait_state_slave_if;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERROR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERROR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERROR
    );
endinterface

// File: rtl/apb_wait_state_slave.sv
// APB completer with word RAM, CTRL/ID/STATUS regs, programmable wait states, one-shot error.
// Ports: HCLK, HRESET (sync, active-high), apb (slave modport of apb_wait_state_slave_if).
module apb_wait_state_slave #(
    parameter int          DEPTH       = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    apb_wait_state_slave_if.slave        apb
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] off_q;
    logic [31:0] wdata_q;
    logic        wr_q;
    logic        err_q;
    logic        hit_q;
    logic [3:0]  wait_q;
    logic        err_once_q;
    logic [15:0] rdcnt_q;
    logic [15:0] wrcnt_q;
    logic [31:0] ram [2**IW];

    logic        setup;
    logic        done;
    logic        ready;
    logic [31:0] p_off;
    logic        p_err;
    logic [31:0] rdata;

    function automatic logic [3:0] decode(input logic [31:0] off);
        // {stat, id, ctrl, ram}
        decode = {off == 32'h108, off == 32'h104,
                  off == 32'h100, off < 32'(4 * DEPTH)};
    endfunction

    logic [3:0] p_dec;
    logic [3:0] q_dec;

    assign p_off = apb.PADDR - BASE_ADDR;
    assign p_dec = decode(p_off);
    assign q_dec = decode(off_q);

    // Error is fixed at setup; ERR_ONCE sampled here so a later CTRL write cannot affect it.
    assign p_err = (|p_off[1:0]) | ~(|p_dec) | (apb.PWRITE & p_dec[2]) | err_once_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        setup   = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (apb.PSEL && !apb.PENABLE) begin
                    setup   = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!apb.PSEL) begin
                    state_d = IDLE;
                end else if (!apb.PENABLE) begin
                    // Abandon the current transfer and restart as a new setup.
                    setup = 1'b1;
                end else if (cnt_q == 4'd0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (setup) begin
            cnt_d = wait_q;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            off_q      <= 32'd0;
            wdata_q    <= 32'd0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            hit_q      <= 1'b0;
            wait_q     <= 4'(WAIT_STATES);
            err_once_q <= 1'b0;
            rdcnt_q    <= 16'd0;
            wrcnt_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (setup) begin
                off_q   <= p_off;
                wdata_q <= apb.PWDATA;
                wr_q    <= apb.PWRITE;
                err_q   <= p_err;
                hit_q   <= err_once_q;
            end
            if (done) begin
                if (hit_q) begin
                    err_once_q <= 1'b0;
                end
                if (!err_q) begin
                    if (wr_q && q_dec[3]) begin
                        rdcnt_q <= 16'd0;
                        wrcnt_q <= 16'd0;
                    end else if (wr_q) begin
                        if (q_dec[1]) begin
                            wait_q     <= wdata_q[3:0];
                            err_once_q <= wdata_q[8];
                        end
                        if (wrcnt_q != 16'hFFFF) begin
                            wrcnt_q <= wrcnt_q + 16'd1;
                        end
                    end else if (rdcnt_q != 16'hFFFF) begin
                        rdcnt_q <= rdcnt_q + 16'd1;
                    end
                end
            end
        end
    end

    // RAM is not reset; a reset landing on the completion edge suppresses the write.
    always_ff @(posedge HCLK) begin
        if (!HRESET && done && !err_q && wr_q && q_dec[0]) begin
            ram[off_q[IW+1:2]] <= wdata_q;
        end
    end

    always_comb begin
        rdata = 32'd0;
        unique case (1'b1)
            q_dec[0]: rdata = ram[off_q[IW+1:2]];
            q_dec[1]: rdata = {23'd0, err_once_q, 4'd0, wait_q};
            q_dec[2]: rdata = ID_VALUE;
            q_dec[3]: rdata = {rdcnt_q, wrcnt_q};
            default:  rdata = 32'd0;
        endcase
    end

    assign ready         = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign apb.PREADY    = ready;
    assign apb.PSLVERROR = ready & err_q;
    assign apb.PRDATA    = (ready && !wr_q && !err_q) ? rdata : 32'd0;

endmodule

// File: tb/tb_apb_wait_state_slave.sv
// Directed testbench for apb_wait_state_slave.
// Drives APB transfers on the falling edge and samples responses 1ns later.
module tb_apb_wait_state_slave;

    logic HCLK;
    logic HRESET;
    int   nchk;
    int   nerr;

    logic [31:0] rd;
    logic        er;
    int          st;

    apb_wait_state_slave_if apb ();

    apb_wait_state_slave dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .apb    (apb.slave)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rdat, output logic e, output int stalls);
        @(negedge HCLK);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = w;
        apb.PADDR   = a;
        apb.PWDATA  = d;
        @(negedge HCLK);
        apb.PENABLE = 1'b1;
        #1;
        stalls = 0;
        while (!apb.PREADY && stalls < 40) begin
            @(negedge HCLK);
            #1;
            stalls++;
        end
        if (stalls >= 40) chk("timeout", 32'd0, 32'd1);
        rdat = apb.PRDATA;
        e    = apb.PSLVERROR;
        @(negedge HCLK);
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
    endtask

    initial begin
        nchk = 0;
        nerr = 0;
        HRESET      = 1'b1;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = 32'd0;
        apb.PWDATA  = 32'd0;
        repeat (3) @(negedge HCLK);
        #1;
        chk("rst_pready", {31'd0, apb.PREADY}, 32'd0);
        chk("rst_perr", {31'd0, apb.PSLVERROR}, 32'd0);
        chk("rst_prdata", apb.PRDATA, 32'd0);
        HRESET = 1'b0;

        // 1: ID read with reset wait states
        xfer(1'b0, 32'h104, 32'd0, rd, er, st);
        chk("id_stalls", 32'(st), 32'd2);
        chk("id_data", rd, 32'hA5B0_0001);
        chk("id_err", {31'd0, er}, 32'd0);

        // 2: clear STATUS, zero waits, RAM write/read, counters
        xfer(1'b1, 32'h108, 32'h0, rd, er, st);
        chk("stat_clr_err", {31'd0, er}, 32'd0);
        xfer(1'b1, 32'h100, 32'h0, rd, er, st);
        chk("ctrl_wr_stalls", 32'(st), 32'd2);
        xfer(1'b1, 32'h00C, 32'hDEAD_BEEF, rd, er, st);
        chk("ram_wr_stalls", 32'(st), 32'd0);
        xfer(1'b0, 32'h00C, 32'd0, rd, er, st);
        chk("ram_rd_stalls", 32'(st), 32'd0);
        chk("ram_rd_data", rd, 32'hDEAD_BEEF);
        xfer(1'b0, 32'h108, 32'd0, rd, er, st);
        chk("status_a", rd, 32'h0001_0002);

        // 3: error responses
        xfer(1'b1, 32'h104, 32'h1234_5678, rd, er, st);
        chk("wr_id_err", {31'd0, er}, 32'd1);
        xfer(1'b0, 32'h002, 32'd0, rd, er, st);
        chk("unalign_err", {31'd0, er}, 32'd1);
        chk("unalign_data", rd, 32'd0);
        xfer(1'b0, 32'h200, 32'd0, rd, er, st);
        chk("unmap_err", {31'd0, er}, 32'd1);
        chk("unmap_data", rd, 32'd0);
        xfer(1'b0, 32'h108, 32'd0, rd, er, st);
        chk("status_b", rd, 32'h0002_0002);
        xfer(1'b0, 32'h104, 32'd0, rd, er, st);
        chk("id_again", rd, 32'hA5B0_0001);

        // 4: one-shot error injection
        xfer(1'b1, 32'h000, 32'h1234_5678, rd, er, st);
        xfer(1'b1, 32'h100, 32'h0000_0100, rd, er, st);
        xfer(1'b1, 32'h000, 32'h0000_0001, rd, er, st);
        chk("once_err", {31'd0, er}, 32'd1);
        xfer(1'b0, 32'h000, 32'd0, rd, er, st);
        chk("once_after_err", {31'd0, er}, 32'd0);
        chk("once_ram0", rd, 32'h1234_5678);
        xfer(1'b0, 32'h100, 32'd0, rd, er, st);
        chk("once_ctrl", rd, 32'h0000_0000);

        // 5: abort by PSEL drop at WAIT=15
        xfer(1'b1, 32'h100, 32'h0000_000F, rd, er, st);
        xfer(1'b1, 32'h014, 32'hCAFE_0005, rd, er, st);
        chk("w15_stalls", 32'(st), 32'd15);
        @(negedge HCLK);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b1;
        apb.PADDR   = 32'h014;
        apb.PWDATA  = 32'h1111_1111;
        repeat (5) begin
            @(negedge HCLK);
            apb.PENABLE = 1'b1;
        end
        @(negedge HCLK);
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        @(negedge HCLK);
        #1;
        chk("abort_pready", {31'd0, apb.PREADY}, 32'd0);
        xfer(1'b0, 32'h014, 32'd0, rd, er, st);
        chk("abort_stalls", 32'(st), 32'd15);
        chk("abort_data", rd, 32'hCAFE_0005);

        // 6: reset in the middle of a stalled write
        @(negedge HCLK);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b1;
        apb.PADDR   = 32'h014;
        apb.PWDATA  = 32'h2222_2222;
        repeat (3) begin
            @(negedge HCLK);
            apb.PENABLE = 1'b1;
        end
        @(negedge HCLK);
        HRESET = 1'b1;
        @(negedge HCLK);
        #1;
        chk("mrst_pready", {31'd0, apb.PREADY}, 32'd0);
        chk("mrst_perr", {31'd0, apb.PSLVERROR}, 32'd0);
        chk("mrst_prdata", apb.PRDATA, 32'd0);
        HRESET      = 1'b0;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        xfer(1'b0, 32'h100, 32'd0, rd, er, st);
        chk("mrst_ctrl", rd, 32'h0000_0002);
        chk("mrst_stalls", 32'(st), 32'd2);
        xfer(1'b0, 32'h014, 32'd0, rd, er, st);
        chk("mrst_ram", rd, 32'hCAFE_0005);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
